// File: rtl/irq_controller.sv
// Programmable interrupt controller: latches edge/level device requests, masks them,
// reports the highest-priority source and drives a registered HWInt vector with post-ACK holdoff.
module irq_controller #(
    parameter int N_SRC   = 6,
    parameter int HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             sys_rstn,
    input  logic [7:0]       Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic [N_SRC-1:0] HWInt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HOLDOFF
    } state_t;

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_MASK     = 3'd1;
    localparam logic [2:0] REG_EDGE_SEL = 3'd2;
    localparam logic [2:0] REG_CURRENT  = 3'd3;
    localparam logic [2:0] REG_ACK      = 3'd4;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] hwint_q, hwint_d;

    logic [2:0]       reg_sel;
    logic [2:0]       ack_id;
    logic             ack_valid;
    logic [N_SRC-1:0] ack_onehot;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] active;
    logic             cur_valid;
    logic [2:0]       cur_id;
    logic             unused_ok;

    assign unused_ok = ^{Addr[7:5], Addr[1:0], Din[31:N_SRC]};

    always_comb begin
        reg_sel    = Addr[4:2];
        ack_id     = Din[2:0];
        ack_valid  = WE && (reg_sel == REG_ACK) && ({1'b0, ack_id} < 4'(N_SRC));
        ack_onehot = ack_valid ? ({{(N_SRC-1){1'b0}}, 1'b1} << ack_id) : '0;
        clr        = ((WE && (reg_sel == REG_PENDING)) ? Din[N_SRC-1:0] : '0) | ack_onehot;
        rise       = irq_in & ~irq_prev_q;

        // Set wins over clear for edge sources; level sources simply follow the line.
        pending_d  = (edge_sel_q & ((pending_q & ~clr) | rise)) | (~edge_sel_q & irq_in);
        mask_d     = (WE && (reg_sel == REG_MASK)) ? Din[N_SRC-1:0] : mask_q;
        edge_sel_d = (WE && (reg_sel == REG_EDGE_SEL)) ? Din[N_SRC-1:0] : edge_sel_q;

        active    = pending_q & mask_q;
        cur_valid = |active;
        cur_id    = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) cur_id = 3'(i);
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        // Any valid ACK (re)starts holdoff, even when the acknowledged source was idle.
        if (ack_valid) begin
            state_d = ST_HOLDOFF;
            cnt_d   = 8'(HOLDOFF - 1);
        end else begin
            unique case (state_q)
                ST_IDLE:    if (cur_valid) state_d = ST_ACTIVE;
                ST_ACTIVE:  if (!cur_valid) state_d = ST_IDLE;
                ST_HOLDOFF: begin
                    if (cnt_q == 8'd0) state_d = ST_IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                default:    state_d = ST_IDLE;
            endcase
        end

        hwint_d = (state_q == ST_HOLDOFF) ? '0 : active;

        Dout = 32'd0;
        case (reg_sel)
            REG_PENDING:  Dout = 32'(pending_q);
            REG_MASK:     Dout = 32'(mask_q);
            REG_EDGE_SEL: Dout = 32'(edge_sel_q);
            REG_CURRENT:  Dout = {cur_valid, 28'd0, cur_id};
            default:      Dout = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= '1;
            irq_prev_q <= '0;
            hwint_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            irq_prev_q <= irq_in;
            hwint_q    <= hwint_d;
        end
    end

    assign HWInt = hwint_q;

endmodule

// File: tb/tb_irq_controller.sv
// Table-driven bench for irq_controller: one row per clock cycle with hand-computed
// HWInt/Dout expectations, plus a hand-written holdoff-reload sequence.
module tb_irq_controller;

    logic        clk;
    logic        sys_rstn;
    logic [7:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  irq_in;
    logic [5:0]  HWInt;

    int n_vectors;
    int n_miscompares;

    typedef struct {
        logic        rstn;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [5:0]  irq;
        logic [5:0]  exp_hw;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    irq_controller #(.N_SRC(6), .HOLDOFF(4)) dut (
        .clk      (clk),
        .sys_rstn (sys_rstn),
        .Addr     (Addr),
        .WE       (WE),
        .Din      (Din),
        .Dout     (Dout),
        .irq_in   (irq_in),
        .HWInt    (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rstn, input logic we, input logic [7:0] addr,
                                input logic [31:0] din, input logic [5:0] irq,
                                input logic [5:0] exp_hw, input logic [31:0] exp_dout);
        vec_t v;
        v.rstn = rstn; v.we = we; v.addr = addr; v.din = din; v.irq = irq;
        v.exp_hw = exp_hw; v.exp_dout = exp_dout;
        return v;
    endfunction

    task automatic applyStimulus(input logic rstn, input logic we, input logic [7:0] addr,
                                 input logic [31:0] din, input logic [5:0] irq);
        sys_rstn = rstn;
        WE       = we;
        Addr     = addr;
        Din      = din;
        irq_in   = irq;
        n_vectors++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives inputs mid-cycle, checks just after, and lets the next posedge consume them.
    task automatic run_cycle(input string tag, input logic rstn, input logic we, input logic [7:0] addr,
                             input logic [31:0] din, input logic [5:0] irq,
                             input logic [5:0] exp_hw, input logic [31:0] exp_dout);
        @(negedge clk);
        applyStimulus(rstn, we, addr, din, irq);
        #1;
        checkOutput({tag, " HWInt"}, {26'd0, HWInt}, {26'd0, exp_hw});
        checkOutput({tag, " Dout"}, Dout, exp_dout);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int zeros;
        logic seen;
        n_vectors     = 0;
        n_miscompares = 0;

        // Reset hold with all request lines high
        vecs.push_back(mk(0, 0, 8'h00, 32'h0, 6'h3F, 6'h00, 32'h0));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0, 6'h3F, 6'h00, 32'h0));
        vecs.push_back(mk(0, 0, 8'h08, 32'h0, 6'h3F, 6'h00, 32'h3F));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h00, 6'h00, 32'h0));
        // Edge latch on source 0, then W1C
        vecs.push_back(mk(1, 1, 8'h04, 32'h1, 6'h00, 6'h00, 32'h0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h01, 6'h00, 32'h0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h00, 6'h00, 32'h1));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h00, 6'h01, 32'h8000_0000));
        vecs.push_back(mk(1, 1, 8'h00, 32'h1, 6'h00, 6'h01, 32'h1));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h00, 6'h01, 32'h0));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h00, 6'h00, 32'h0));
        // Priority between sources 3 and 1, ACK 1, holdoff on edge sources
        vecs.push_back(mk(1, 1, 8'h04, 32'h3F, 6'h00, 6'h00, 32'h1));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h0A, 6'h00, 32'h0));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h0A, 6'h00, 32'h8000_0001));
        vecs.push_back(mk(1, 1, 8'h10, 32'h1, 6'h0A, 6'h0A, 32'h0));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h0A, 6'h0A, 32'h8000_0003));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h00, 6'h00, 32'h08));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h00, 6'h00, 32'h8000_0003));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h00, 6'h00, 32'h08));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h00, 6'h00, 32'h08));
        vecs.push_back(mk(1, 1, 8'h00, 32'h08, 6'h00, 6'h08, 32'h08));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h00, 6'h08, 32'h0));
        // Level source 2 with holdoff of exactly four cycles
        vecs.push_back(mk(1, 1, 8'h08, 32'h3B, 6'h00, 6'h00, 32'h3F));
        vecs.push_back(mk(1, 1, 8'h04, 32'h04, 6'h04, 6'h00, 32'h3F));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h04, 6'h00, 32'h04));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h04, 6'h04, 32'h8000_0002));
        vecs.push_back(mk(1, 1, 8'h10, 32'h2, 6'h04, 6'h04, 32'h0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h04, 6'h04, 32'h04));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h04, 6'h00, 32'h04));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h04, 6'h04, 32'h04));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h04, 6'h04, 32'h8000_0002));
        // Set beats clear, W1C of idle and level bits
        vecs.push_back(mk(1, 1, 8'h00, 32'h10, 6'h14, 6'h04, 32'h04));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h04, 32'h14));
        vecs.push_back(mk(1, 1, 8'h00, 32'h01, 6'h14, 6'h04, 32'h14));
        vecs.push_back(mk(1, 1, 8'h00, 32'h04, 6'h14, 6'h04, 32'h14));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h04, 32'h14));
        // Out-of-range ACK id and undefined register slots are ignored
        vecs.push_back(mk(1, 1, 8'h10, 32'h7, 6'h14, 6'h04, 32'h0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h04, 32'h14));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h04, 32'h14));
        vecs.push_back(mk(1, 1, 8'h14, 32'hFFFF_FFFF, 6'h14, 6'h04, 32'h0));
        vecs.push_back(mk(1, 0, 8'h04, 32'h0, 6'h14, 6'h04, 32'h04));
        vecs.push_back(mk(1, 0, 8'h1C, 32'h0, 6'h14, 6'h04, 32'h0));
        // Reset in the middle of holdoff
        vecs.push_back(mk(1, 1, 8'h10, 32'h4, 6'h14, 6'h04, 32'h0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h04, 32'h04));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0, 6'h14, 6'h00, 32'h04));
        vecs.push_back(mk(1, 0, 8'h04, 32'h0, 6'h14, 6'h00, 32'h0));
        vecs.push_back(mk(1, 0, 8'h08, 32'h0, 6'h14, 6'h00, 32'h3F));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h00, 32'h14));
        vecs.push_back(mk(1, 1, 8'h04, 32'h10, 6'h14, 6'h00, 32'h0));
        vecs.push_back(mk(1, 0, 8'h0C, 32'h0, 6'h14, 6'h00, 32'h8000_0004));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 6'h14, 6'h10, 32'h14));

        sys_rstn = 1'b0;
        WE       = 1'b0;
        Addr     = 8'h00;
        Din      = 32'h0;
        irq_in   = 6'h3F;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            run_cycle($sformatf("row%0d", i), vecs[i].rstn, vecs[i].we, vecs[i].addr,
                      vecs[i].din, vecs[i].irq, vecs[i].exp_hw, vecs[i].exp_dout);
        end

        // A second ACK during holdoff reloads the counter: 2 + 4 zero cycles instead of 4
        run_cycle("reload_edge_sel", 1, 1, 8'h08, 32'h3B, 6'h14, 6'h10, 32'h3F);
        run_cycle("reload_mask",     1, 1, 8'h04, 32'h04, 6'h14, 6'h10, 32'h10);
        run_cycle("reload_settle0",  1, 0, 8'h00, 32'h0,  6'h14, 6'h10, 32'h14);
        run_cycle("reload_settle1",  1, 0, 8'h00, 32'h0,  6'h14, 6'h04, 32'h14);
        run_cycle("reload_ack1",     1, 1, 8'h10, 32'h2,  6'h14, 6'h04, 32'h0);
        run_cycle("reload_gap",      1, 0, 8'h00, 32'h0,  6'h14, 6'h04, 32'h14);
        zeros = 0;
        seen  = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1, 8'h10, 32'h2, 6'h14);
        #1;
        if (HWInt == 6'h00) zeros++;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            applyStimulus(1, 0, 8'h00, 32'h0, 6'h14);
            #1;
            if (HWInt == 6'h00) zeros++;
            else seen = 1'b1;
        end
        checkOutput("reload_recover", {31'd0, seen}, 32'd1);
        checkOutput("reload_zero_cycles", zeros, 32'd6);
        checkOutput("reload_final_hwint", {26'd0, HWInt}, 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
